writeback_ctrl: RTL and testbench
=================================

WRITEBACK_CTRL -- requirements
Module: writeback_ctrl

Interface
REQ-001 Parameter MEM_LAT, default 2, SHALL set the memory-read wait cycles before writing a load source.
REQ-002 Parameter MD_TIMEOUT, default 40, SHALL set the maximum cycles spent waiting on the mult/div unit.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 wb_req  input  1  SHALL request one register-file writeback; sampled only in IDLE.
REQ-006 wb_src  input  4  SHALL be the writeback source code, sampled with wb_req. Codes: 0 ALUOut, 1 LoadSize, 2 MemData, 3 RD, 4 SE1_32, 5 const 227, 6 RegB, 7 HI, 8 LO.
REQ-007 wb_abort  input  1  SHALL cancel a pending writeback (exception path).
REQ-008 muldiv_busy  input  1  SHALL mean HI/LO are not yet valid.
REQ-009 MemtoReg  output  4  SHALL drive the writeback source mux select.
REQ-010 RegWrite  output  1  SHALL drive the register-file write enable.
REQ-011 wb_busy  output  1  SHALL be high in every state except IDLE.
REQ-012 wb_done  output  1  SHALL pulse for one cycle, coincident with RegWrite.
REQ-013 err_illegal  output  1  SHALL pulse for one cycle when an illegal code is requested.
REQ-014 err_timeout  output  1  SHALL pulse for one cycle when a mult/div wait times out.

Function
REQ-015 FSM states SHALL be IDLE, MEM_WAIT, MD_WAIT and WRITE.
REQ-016 Leaving IDLE on wb_req with a legal code, wb_src SHALL be latched into src_q, and the next state SHALL be:
- MEM_WAIT for codes 1 or 2, with the wait counter loaded to MEM_LAT;
- MD_WAIT for codes 7 or 8, with the counter loaded to MD_TIMEOUT;
- WRITE for all other legal codes.
REQ-017 wb_req with wb_src >= 9 in IDLE SHALL:
- assert err_illegal in the next cycle;
- remain in IDLE;
- produce no RegWrite.
REQ-018 MEM_WAIT SHALL decrement the counter each cycle and go to WRITE in the cycle after the counter reaches 1. Load latency from req to RegWrite SHALL be MEM_LAT+1 cycles.
REQ-019 MD_WAIT SHALL go to WRITE on the first cycle that samples muldiv_busy low. Minimum latency from req to RegWrite SHALL be 2 cycles.
REQ-020 MD_WAIT with the counter expired and muldiv_busy still high SHALL:
- pulse err_timeout;
- return to IDLE;
- produce no RegWrite.
REQ-021 WRITE SHALL:
- assert RegWrite=1 and wb_done=1 for exactly one cycle;
- return to IDLE.
REQ-022 Immediate sources SHALL have a req-to-RegWrite latency of 1 cycle.
REQ-023 MemtoReg SHALL equal src_q in MEM_WAIT, MD_WAIT and WRITE, holding steady through the waits, and SHALL be 0000 in IDLE.
REQ-024 wb_abort in MEM_WAIT or MD_WAIT SHALL return the FSM to IDLE the next cycle, with no RegWrite, wb_done or error pulse.
REQ-025 wb_abort in WRITE or IDLE SHALL be ignored; a write already in progress completes.
REQ-026 wb_req while wb_busy=1 SHALL be ignored; the requester re-issues it after wb_busy falls.
REQ-027 When wb_abort and the timeout expiry coincide, abort SHALL take priority and err_timeout SHALL NOT pulse.
REQ-028 Back-to-back operation: a wb_req in the IDLE cycle immediately after WRITE SHALL be accepted.

Reset
REQ-029 While reset=1 at a clock edge, the FSM SHALL enter IDLE, with src_q=0 and counter=0.
REQ-030 After reset, outputs SHALL be: MemtoReg=0000, RegWrite=0, wb_busy=0, wb_done=0, err_illegal=0, err_timeout=0.
REQ-031 Reset SHALL override wb_req and wb_abort.
REQ-032 Reset mid-wait or in WRITE SHALL suppress any RegWrite in the following cycle.

Structure
REQ-033 A shared package SHALL hold:
- the 4-bit source-code constants (SRC_ALUOUT through SRC_LO);
- SRC_MAX = 8;
- the FSM state encoding.
REQ-034 Counter width SHALL be clog2(max(MEM_LAT, MD_TIMEOUT)+1).
REQ-035 One sub-module, wb_wait_counter (loadable down-counter with zero flag), SHALL be shared by the MEM_WAIT and MD_WAIT paths.

Verification
REQ-036 wb_req, wb_src=0 at cycle 0 -> RegWrite=1, MemtoReg=0000, wb_done=1 at cycle 1; wb_busy=0 at cycle 2.
REQ-037 wb_src=2, MEM_LAT=2 -> MemtoReg=0010 through cycles 1-3; RegWrite=1 at cycle 3 only.
REQ-038 wb_src=7, muldiv_busy high for 10 cycles -> MemtoReg=0111 held; RegWrite=1 exactly one cycle after muldiv_busy falls.
REQ-039 wb_src=8, muldiv_busy stuck high, MD_TIMEOUT=40 -> err_timeout pulse at cycle 41; no RegWrite; IDLE afterwards.
REQ-040 Abort and illegal-code cases:
- wb_src=1, wb_abort at cycle 1 -> IDLE at cycle 2, with no RegWrite;
- wb_src=9 -> err_illegal=1 at cycle 1, with wb_busy remaining 0.
REQ-041 Reset asserted during MEM_WAIT -> all outputs zero the next cycle, with no RegWrite.

Source files
------------

// File: rtl/writeback_ctrl_pkg.sv
// Shared definitions for the register-file writeback controller: source codes,
// FSM state encoding and source classification helpers.
package writeback_ctrl_pkg;

    localparam logic [3:0] SRC_ALUOUT   = 4'd0;
    localparam logic [3:0] SRC_LOADSIZE = 4'd1;
    localparam logic [3:0] SRC_MEMDATA  = 4'd2;
    localparam logic [3:0] SRC_RD       = 4'd3;
    localparam logic [3:0] SRC_SE1_32   = 4'd4;
    localparam logic [3:0] SRC_CONST227 = 4'd5;
    localparam logic [3:0] SRC_REGB     = 4'd6;
    localparam logic [3:0] SRC_HI       = 4'd7;
    localparam logic [3:0] SRC_LO       = 4'd8;
    localparam logic [3:0] SRC_MAX      = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MD_WAIT  = 2'd2,
        ST_WRITE    = 2'd3
    } wb_state_e;

    function automatic logic is_mem_src(input logic [3:0] src);
        return (src == SRC_LOADSIZE) || (src == SRC_MEMDATA);
    endfunction

    function automatic logic is_md_src(input logic [3:0] src);
        return (src == SRC_HI) || (src == SRC_LO);
    endfunction

endpackage

// File: rtl/wb_wait_counter.sv
// Loadable down-counter with zero flag, shared by the memory-latency and
// mult/div-timeout waits. Decrement saturates at zero.
module wb_wait_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/writeback_ctrl.sv
// Register-file writeback sequencer: selects the writeback source, waits for
// memory latency or the mult/div unit, and issues a single-cycle RegWrite.
module writeback_ctrl
    import writeback_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned MD_TIMEOUT = 40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wb_req,
    input  logic [3:0] wb_src,
    input  logic       wb_abort,
    input  logic       muldiv_busy,
    output logic [3:0] MemtoReg,
    output logic       RegWrite,
    output logic       wb_busy,
    output logic       wb_done,
    output logic       err_illegal,
    output logic       err_timeout,
    output wb_state_e  dbg_state_o
);

    localparam int unsigned CNT_MAX = (MEM_LAT > MD_TIMEOUT) ? MEM_LAT : MD_TIMEOUT;
    localparam int CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    wb_state_e        state_q, state_d;
    logic [3:0]       src_q, src_d;
    logic             err_illegal_q, err_illegal_d;
    logic             err_timeout_q, err_timeout_d;
    logic             cnt_load, cnt_dec, cnt_zero, cnt_last;
    logic [CNT_W-1:0] cnt_load_val, cnt_val;

    wb_wait_counter #(.W(CNT_W)) u_wait_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .count_o    (cnt_val),
        .zero_o     (cnt_zero)
    );

    // The wait ends in the cycle the counter shows 1 (or 0 for a zero-length load).
    assign cnt_last = cnt_zero || (cnt_val == CNT_W'(1));

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        cnt_load      = 1'b0;
        cnt_load_val  = '0;
        cnt_dec       = 1'b0;
        err_illegal_d = 1'b0;
        err_timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wb_req) begin
                    if (wb_src > SRC_MAX) begin
                        err_illegal_d = 1'b1;
                    end else begin
                        src_d = wb_src;
                        if (is_mem_src(wb_src)) begin
                            state_d      = ST_MEM_WAIT;
                            cnt_load     = 1'b1;
                            cnt_load_val = CNT_W'(MEM_LAT);
                        end else if (is_md_src(wb_src)) begin
                            state_d      = ST_MD_WAIT;
                            cnt_load     = 1'b1;
                            cnt_load_val = CNT_W'(MD_TIMEOUT);
                        end else begin
                            state_d = ST_WRITE;
                        end
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (wb_abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_last) begin
                    state_d = ST_WRITE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                // Abort beats both completion and timeout.
                if (wb_abort) begin
                    state_d = ST_IDLE;
                end else if (!muldiv_busy) begin
                    state_d = ST_WRITE;
                end else if (cnt_last) begin
                    state_d       = ST_IDLE;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            src_q         <= '0;
            err_illegal_q <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            err_illegal_q <= err_illegal_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign MemtoReg    = (state_q == ST_IDLE) ? 4'd0 : src_q;
    assign RegWrite    = (state_q == ST_WRITE);
    assign wb_done     = (state_q == ST_WRITE);
    assign wb_busy     = (state_q != ST_IDLE);
    assign err_illegal = err_illegal_q;
    assign err_timeout = err_timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_writeback_ctrl.sv
// Directed bench for writeback_ctrl: stimulus is laid out on an absolute cycle
// timeline, and a timeline model projects every output for every cycle.
module tb_writeback_ctrl;
    import writeback_ctrl_pkg::*;

    localparam int MEM_LAT    = 2;
    localparam int MD_TIMEOUT = 40;
    localparam int N          = 360;
    localparam int NA         = N + 64;

    logic       clk = 1'b0;
    logic       reset, wb_req, wb_abort, muldiv_busy;
    logic [3:0] wb_src;
    logic [3:0] MemtoReg;
    logic       RegWrite, wb_busy, wb_done, err_illegal, err_timeout;
    wb_state_e  dbg_state;

    writeback_ctrl #(.MEM_LAT(MEM_LAT), .MD_TIMEOUT(MD_TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb_req      (wb_req),
        .wb_src      (wb_src),
        .wb_abort    (wb_abort),
        .muldiv_busy (muldiv_busy),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .wb_busy     (wb_busy),
        .wb_done     (wb_done),
        .err_illegal (err_illegal),
        .err_timeout (err_timeout),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    // Stimulus timeline: entry c is driven during cycle c.
    bit       rst_a[NA], req_a[NA], abort_a[NA], busy_a[NA];
    bit [3:0] src_a[NA];
    // Expected outputs: entry c holds the outputs seen after c rising edges.
    bit       e_busy[NA], e_rw[NA], e_ill[NA], e_to[NA];
    bit [3:0] e_m2r[NA];

    int n_checks = 0;
    int n_fail   = 0;
    int edges    = 0;
    bit running  = 1'b0;

    task automatic check(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, c, act, exp);
        end
    endtask

    task automatic add_req(input int c, input bit [3:0] s);
        req_a[c] = 1'b1;
        src_a[c] = s;
    endtask

    task automatic set_busy(input int from, input int upto);
        for (int k = from; k <= upto; k++) busy_a[k] = 1'b1;
    endtask

    // Project each accepted request onto the timeline: which cycles are busy,
    // when RegWrite lands, and which error pulse (if any) follows.
    task automatic build_model();
        int free = 0;
        for (int t = 0; t < N; t++) begin
            int s, last, w;
            bit tout;
            if (rst_a[t]) begin
                for (int k = t + 1; k < NA; k++) begin
                    e_busy[k] = 0; e_rw[k] = 0; e_ill[k] = 0; e_to[k] = 0; e_m2r[k] = 0;
                end
                free = t + 1;
                continue;
            end
            if (t < free || !req_a[t]) continue;
            s = int'(src_a[t]);
            if (s > 8) begin
                e_ill[t + 1] = 1'b1;
                free = t + 1;
                continue;
            end
            w = -1;
            tout = 1'b0;
            if (s == 1 || s == 2) begin
                w = t + MEM_LAT + 1;
                last = w;
                for (int k = t + 1; k < t + MEM_LAT + 1; k++) begin
                    if (abort_a[k]) begin
                        last = k;
                        w = -1;
                        break;
                    end
                end
            end else if (s == 7 || s == 8) begin
                last = t + MD_TIMEOUT;
                tout = 1'b1;
                for (int k = t + 1; k <= t + MD_TIMEOUT; k++) begin
                    if (abort_a[k]) begin
                        last = k; tout = 1'b0;
                        break;
                    end else if (!busy_a[k]) begin
                        w = k + 1; last = w; tout = 1'b0;
                        break;
                    end
                end
            end else begin
                w = t + 1;
                last = w;
            end
            for (int k = t + 1; k <= last; k++) begin
                e_busy[k] = 1'b1;
                e_m2r[k]  = 4'(s);
            end
            if (w >= 0) e_rw[w] = 1'b1;
            if (tout) e_to[last + 1] = 1'b1;
            free = last + 1;
        end
    endtask

    always @(posedge clk) edges <= edges + 1;

    always @(negedge clk) begin
        if (running && edges >= 1 && edges < N) begin
            check("MemtoReg",    edges, 32'(MemtoReg),    32'(e_m2r[edges]));
            check("RegWrite",    edges, 32'(RegWrite),    32'(e_rw[edges]));
            check("wb_done",     edges, 32'(wb_done),     32'(e_rw[edges]));
            check("wb_busy",     edges, 32'(wb_busy),     32'(e_busy[edges]));
            check("err_illegal", edges, 32'(err_illegal), 32'(e_ill[edges]));
            check("err_timeout", edges, 32'(err_timeout), 32'(e_to[edges]));
        end
    end

    initial begin
        reset = 1'b1; wb_req = 1'b0; wb_src = 4'd0; wb_abort = 1'b0; muldiv_busy = 1'b0;

        rst_a[0] = 1; rst_a[1] = 1;
        add_req(5, 4'd0);                                       // immediate ALUOut
        add_req(10, 4'd2);                                      // MemData load
        add_req(20, 4'd7); set_busy(20, 30);                    // HI, unit busy 10 wait cycles
        add_req(40, 4'd8); set_busy(40, 100);                   // LO, stuck busy -> timeout
        add_req(110, 4'd1); abort_a[111] = 1;                   // load aborted
        add_req(120, 4'd9);                                     // illegal code
        add_req(130, 4'd2); rst_a[132] = 1;                     // reset mid-wait
        add_req(140, 4'd5); add_req(142, 4'd6);                 // back-to-back
        add_req(150, 4'd2); add_req(151, 4'd0);                 // req while busy ignored
        add_req(160, 4'd7); set_busy(160, 210); abort_a[200] = 1; // abort meets timeout
        add_req(220, 4'd3); abort_a[221] = 1;                   // abort in WRITE ignored
        abort_a[228] = 1;                                       // abort in IDLE ignored
        for (int i = 0; i < 16; i++) add_req(230 + 6 * i, 4'(i));
        add_req(340, 4'd0); rst_a[341] = 1;                     // reset in WRITE

        build_model();

        check("model_imm_rw",      6,   32'(e_rw[6]),    1);
        check("model_imm_idle",    7,   32'(e_busy[7]),  0);
        check("model_mem_sel",     11,  32'(e_m2r[11]),  2);
        check("model_mem_rw_early",12,  32'(e_rw[12]),   0);
        check("model_mem_rw",      13,  32'(e_rw[13]),   1);
        check("model_md_rw",       32,  32'(e_rw[32]),   1);
        check("model_md_rw_early", 31,  32'(e_rw[31]),   0);
        check("model_to_pulse",    81,  32'(e_to[81]),   1);
        check("model_to_idle",     81,  32'(e_busy[81]), 0);
        check("model_abort_idle",  112, 32'(e_busy[112]),0);
        check("model_illegal",     121, 32'(e_ill[121]), 1);
        check("model_rst_norw",    133, 32'(e_rw[133]),  0);
        check("model_b2b_sel",     143, 32'(e_m2r[143]), 6);
        check("model_abort_no_to", 201, 32'(e_to[201]),  0);
        check("model_wr_abort_ign",221, 32'(e_rw[221]),  1);

        running = 1'b1;
        for (int c = 0; c < N; c++) begin
            reset       = rst_a[c];
            wb_req      = req_a[c];
            wb_src      = src_a[c];
            wb_abort    = abort_a[c];
            muldiv_busy = busy_a[c];
            @(posedge clk);
            #1;
        end
        running = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
